// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and serializer state encodings.
`timescale 1ns/1ps
package uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // A programmed divider of zero would stall the bit timer, so it runs as 1.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with registered pointers and a separate occupancy counter.
// A push while full or a pop while empty is ignored.
`timescale 1ns/1ps
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register window decode, TX FIFO,
// programmable bit timer and serializer FSM driving a registered tx line.
`timescale 1ns/1ps
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_wr_en,
  output logic [31:0] data_rd,
  output logic        sel,
  output logic        tx,
  output logic        tx_idle
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    off;
  logic          wr_cycle;
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          ovf_set;
  logic          ovf_clr;
  logic          overflow;
  logic [15:0]   baud_div;
  logic [15:0]   div_m1;
  logic [31:0]   status_word;
  logic          busy;
  logic          unused_ok;

  tx_state_t   state, state_n;
  logic [15:0] baud_cnt, baud_cnt_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;
  logic        tx_n;
  logic        tick;

  assign unused_ok = &{1'b0, data_addr[1:0], data_wr[31:16]};

  assign sel       = (data_addr[31:4] == BASE_ADDR[31:4]);
  assign off       = data_addr[3:2];
  assign wr_cycle  = sel && (data_wr_en != 4'd0);
  assign fifo_push = wr_cycle && (off == REG_TXDATA) && data_wr_en[0];
  // Full is judged on the pre-edge level, so a same-edge pop cannot rescue the push.
  assign ovf_set   = fifo_push && fifo_full;
  assign ovf_clr   = wr_cycle && (off == REG_STATUS) && data_wr_en[0] && data_wr[ST_OVF];
  assign busy      = (state != S_IDLE);
  assign div_m1    = eff_div(baud_div) - 16'd1;
  assign tick      = (baud_cnt == 16'd0);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (data_wr[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_div <= DEFAULT_DIV;
      overflow <= 1'b0;
      tx_idle  <= 1'b1;
    end else begin
      if (wr_cycle && (off == REG_BAUDDIV)) begin
        if (data_wr_en[0]) baud_div[7:0]  <= data_wr[7:0];
        if (data_wr_en[1]) baud_div[15:8] <= data_wr[15:8];
      end
      overflow <= ovf_set || (overflow && !ovf_clr);
      tx_idle  <= (state == S_IDLE) && fifo_empty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      tx       <= tx_n;
    end
  end

  // The bit timer reloads from BAUDDIV only at bit boundaries, so a divider
  // change mid-frame first shapes the following bit.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tx_n       = tx;
    fifo_pop   = 1'b0;
    if (state != S_IDLE && !tick) baud_cnt_n = baud_cnt - 16'd1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_n    = S_START;
          shift_n    = fifo_dout;
          baud_cnt_n = div_m1;
          tx_n       = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_n    = S_DATA;
          baud_cnt_n = div_m1;
          bit_cnt_n  = 3'd0;
          tx_n       = shift[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          baud_cnt_n = div_m1;
          if (bit_cnt == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_n    = S_START;
            shift_n    = fifo_dout;
            baud_cnt_n = div_m1;
            tx_n       = 1'b0;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    status_word           = '0;
    status_word[ST_BUSY]  = busy;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_OVF]   = overflow;
    status_word[15:8]     = 8'(fifo_level);
  end

  always_comb begin
    data_rd = '0;
    if (sel) begin
      case (off)
        REG_STATUS:  data_rd = status_word;
        REG_BAUDDIV: data_rd = {16'd0, baud_div};
        default:     data_rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: a serial-line decoder checks frames against
// a queue of bytes expected on tx, plus cycle-exact waveform and register checks.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] data_wr;
  logic [3:0]  data_wr_en;
  logic [31:0] data_rd;
  logic        sel;
  logic        tx;
  logic        tx_idle;

  int total = 0;
  int bad   = 0;
  int frames = 0;
  bit mon_en = 0;
  int cur_div = 104;
  logic [7:0] exp_q[$];

  uart_tx_mmio #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd104)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_addr  (data_addr),
    .data_wr    (data_wr),
    .data_wr_en (data_wr_en),
    .data_rd    (data_rd),
    .sel        (sel),
    .tx         (tx),
    .tx_idle    (tx_idle)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ideal 8N1 line level at cycle i of a frame carrying b with d cycles per bit.
  function automatic logic frame_bit(input logic [7:0] b, input int d, input int i);
    int seg;
    seg = i / d;
    if (seg == 0) return 1'b0;
    if (seg >= 9) return 1'b1;
    return b[seg-1];
  endfunction

  // ---------------- serial decoder / scoreboard ----------------
  int         mon_d;
  logic [7:0] mon_rx;
  logic [7:0] mon_exp;
  always begin
    @(negedge clk);
    if (mon_en && !rst && tx === 1'b0) begin
      mon_d = (cur_div == 0) ? 1 : cur_div;
      repeat (mon_d / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (mon_d) @(negedge clk);
        mon_rx[i] = tx;
      end
      repeat (mon_d) @(negedge clk);
      check("stop_bit", tx, 1'b1);
      frames++;
      check("frame_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("frame_byte", mon_rx, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
    @(negedge clk);
    data_addr  = a;
    data_wr    = d;
    data_wr_en = en;
    @(posedge clk);
    #1;
    data_wr_en = 4'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    data_addr  = a;
    data_wr_en = 4'd0;
    #1;
    v = data_rd;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (!(tx_idle === 1'b1 && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_in_time"}, (n < budget), 1'b1);
  endtask

  task automatic wait_low(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 12);
  endtask

  task automatic capture(input int len, output logic [63:0] w);
    w = '0;
    w[0] = tx;
    for (int k = 1; k < len; k++) begin
      @(negedge clk);
      w[k] = tx;
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] v;
  logic [63:0] wave;
  logic [63:0] exp_wave;
  int n;
  int lows;
  int busyc;
  int k;
  int frames0;

  initial begin
    rst = 1'b0;
    data_addr = BASE;
    data_wr = '0;
    data_wr_en = 4'd0;
    #1 rst = 1'b1;
    #1;
    // reset state, outputs without any clock edge
    check("rst_tx", tx, 1'b1);
    check("rst_tx_idle", tx_idle, 1'b1);
    check("rst_sel", sel, 1'b1);
    data_addr = BASE + 32'h4;
    #1 check("rst_status", data_rd, 32'h4);
    data_addr = BASE + 32'h8;
    #1 check("rst_bauddiv", data_rd, 32'd104);
    data_addr = BASE + 32'h20;
    #1 check("rst_sel_outside", sel, 1'b0);
    check("rst_rd_outside", data_rd, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("post_rst_quiet", lows, 0);
    mon_en = 1'b1;

    // single byte 0x55 at 4 cycles per bit, cycle-exact
    wr(BASE + 32'h8, 32'd4, 4'b0011);
    cur_div = 4;
    exp_q.push_back(8'h55);
    wr(BASE, 32'h55, 4'b0001);
    wait_low(n);
    check("t55_start_latency", n, 2);
    capture(40, wave);
    exp_wave = '0;
    for (int i = 0; i < 40; i++) exp_wave[i] = frame_bit(8'h55, 4, i);
    check("t55_waveform", wave, exp_wave);
    @(negedge clk);
    check("t55_tx_idle_c40", tx_idle, 1'b0);
    @(negedge clk);
    check("t55_tx_idle_c41", tx_idle, 1'b1);
    wait_idle(100, "t55");

    // overflow: ten pushes on consecutive edges into an 8-deep FIFO
    wr(BASE + 32'h8, 32'd20, 4'b0011);
    cur_div = 20;
    frames0 = frames;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'(8'h30 + i));
      wr(BASE, 32'h30 + i, 4'b0001);
    end
    rd(BASE + 32'h4, v);
    check("ovf_status", v, 32'h0000_080B);
    wr(BASE + 32'h4, 32'h8, 4'b0001);
    rd(BASE + 32'h4, v);
    check("ovf_status_cleared", v, 32'h0000_0803);
    wait_idle(2500, "ovf");
    check("ovf_frame_count", frames - frames0, 9);
    rd(BASE + 32'h4, v);
    check("ovf_status_drained", v, 32'h4);

    // lanes and decode
    wr(BASE + 32'h8, 32'd4, 4'b0011);
    cur_div = 4;
    frames0 = frames;
    exp_q.push_back(8'h41);
    wr(BASE, 32'hAABB_CC41, 4'b1111);
    wr(BASE, 32'h1234_0000, 4'b1100);
    wr(BASE + 32'h10, 32'h99, 4'b1111);
    wr(BASE + 32'h18, 32'h7, 4'b1111);
    wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111);
    rd(BASE + 32'h10, v);
    check("dec_sel_outside", sel, 1'b0);
    check("dec_rd_outside", v, 32'h0);
    rd(BASE + 32'hC, v);
    check("dec_reserved_rd", v, 32'h0);
    rd(BASE, v);
    check("dec_txdata_rd", v, 32'h0);
    rd(BASE + 32'h8, v);
    check("dec_bauddiv_unchanged", v, 32'd4);
    rd(BASE + 32'h4, v);
    check("dec_status_busy", v, 32'h5);
    wait_idle(200, "dec");
    check("dec_frame_count", frames - frames0, 1);

    // BAUDDIV byte lanes and zero divider
    wr(BASE + 32'h8, 32'h0000_AB00, 4'b0010);
    rd(BASE + 32'h8, v);
    check("div_lane1", v, 32'hAB04);
    wr(BASE + 32'h8, 32'h0000_0000, 4'b0010);
    rd(BASE + 32'h8, v);
    check("div_lane1_back", v, 32'h4);
    wr(BASE + 32'h8, 32'h0, 4'b0011);
    cur_div = 0;
    rd(BASE + 32'h8, v);
    check("div_zero_rd", v, 32'h0);
    exp_q.push_back(8'hA5);
    wr(BASE, 32'hA5, 4'b0001);
    wait_idle(100, "div0");

    // back-to-back frames at 2 cycles per bit
    wr(BASE + 32'h8, 32'd2, 4'b0011);
    cur_div = 2;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    wr(BASE, 32'h01, 4'b0001);
    wr(BASE, 32'h80, 4'b0001);
    wait_low(n);
    check("b2b_start_latency", n, 1);
    capture(40, wave);
    exp_wave = '0;
    for (int i = 0; i < 20; i++) begin
      exp_wave[i]      = frame_bit(8'h01, 2, i);
      exp_wave[i + 20] = frame_bit(8'h80, 2, i);
    end
    check("b2b_waveform", wave, exp_wave);
    @(negedge clk);
    check("b2b_tx_idle_c40", tx_idle, 1'b0);
    @(negedge clk);
    check("b2b_tx_idle_c41", tx_idle, 1'b1);
    wait_idle(100, "b2b");

    // BAUDDIV change while bit 3 is on the line
    mon_en = 1'b0;
    wr(BASE + 32'h8, 32'd8, 4'b0011);
    wr(BASE, 32'hFF, 4'b0001);
    @(negedge clk);
    data_addr = BASE + 32'h4;
    n = 1;
    while (tx !== 1'b0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("baud_start_seen", (n < 12), 1'b1);
    k = 0;
    lows = 0;
    busyc = 0;
    while (k < 200) begin
      if (k == 34) begin
        data_addr  = BASE + 32'h4;
        data_wr_en = 4'd0;
      end
      #1;
      if (tx === 1'b0) lows++;
      if (data_rd[0] !== 1'b1) break;
      busyc++;
      if (k == 33) begin
        data_addr  = BASE + 32'h8;
        data_wr    = 32'd2;
        data_wr_en = 4'b0011;
      end
      @(negedge clk);
      k++;
    end
    check("baud_start_len", lows, 8);
    check("baud_frame_len", busyc, 50);
    rd(BASE + 32'h8, v);
    check("baud_new_div", v, 32'd2);

    // asynchronous reset in the middle of a frame
    wr(BASE + 32'h8, 32'd8, 4'b0011);
    wr(BASE, 32'h00, 4'b0001);
    wait_low(n);
    check("rstmid_start_seen", (n < 12), 1'b1);
    repeat (20) @(negedge clk);
    check("rstmid_tx_low_in_data", tx, 1'b0);
    data_addr = BASE + 32'h4;
    rst = 1'b1;
    #1;
    check("rstmid_tx_async", tx, 1'b1);
    check("rstmid_tx_idle_async", tx_idle, 1'b1);
    check("rstmid_status_async", data_rd, 32'h4);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(BASE + 32'h4, v);
    check("rstmid_status", v, 32'h4);
    rd(BASE + 32'h8, v);
    check("rstmid_bauddiv", v, 32'd104);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rstmid_quiet", lows, 0);
    check("rstmid_tx_idle", tx_idle, 1'b1);
    check("queue_empty_at_end", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
